// File: rtl/updown_count_sched_if.sv
// Request/command and counter-control bundle shared between the two
// requesters (master side) and the counter scheduler (slave side).
interface updown_count_sched_if #(
    parameter int WIDTH  = 4,
    parameter int STEP_W = 8
);
    logic [1:0]        req;
    logic [1:0]        op0;
    logic [STEP_W-1:0] arg0;
    logic [1:0]        op1;
    logic [STEP_W-1:0] arg1;
    logic [1:0]        gnt;
    logic              busy;
    logic              done;
    logic              done_id;
    logic              sat_err;
    logic              cnt_en;
    logic              cnt_dir;
    logic              cnt_load;
    logic [WIDTH-1:0]  load_val;
    logic [WIDTH-1:0]  count;

    modport master (
        output req, op0, arg0, op1, arg1,
        input  gnt, busy, done, done_id, sat_err,
        input  cnt_en, cnt_dir, cnt_load, load_val, count
    );

    modport slave (
        input  req, op0, arg0, op1, arg1,
        output gnt, busy, done, done_id, sat_err,
        output cnt_en, cnt_dir, cnt_load, load_val, count
    );
endinterface

// File: rtl/updown_count_sched.sv
// Two-requester round-robin command scheduler for an up/down counter.
// Owns the architectural count and drives enable/direction/load; a settle
// cycle separates every direction change from the next enabled step.
module updown_count_sched #(
    parameter int WIDTH  = 4,
    parameter int STEP_W = 8,
    parameter bit WRAP   = 1'b1
) (
    input  logic                 clk,
    input  logic                 rst,
    updown_count_sched_if.slave  bus
);
    localparam logic [1:0] OP_LOAD = 2'b00;
    localparam logic [1:0] OP_UP   = 2'b01;
    localparam logic [1:0] OP_DOWN = 2'b10;
    localparam logic [1:0] OP_HOLD = 2'b11;

    typedef enum logic [2:0] {IDLE, SETTLE, RUN, LOAD, HOLD, DONE} state_t;

    state_t            state, state_n;
    logic [WIDTH-1:0]  count_q;
    logic              dir_q;
    logic              rr_ptr;
    logic              owner;
    logic              sat_q;
    logic [STEP_W-1:0] rem;
    logic [WIDTH-1:0]  load_q;

    logic              grant;
    logic              win;
    logic [1:0]        sel_op;
    logic [STEP_W-1:0] sel_arg;
    logic              at_term;
    logic              step_sat;

    assign bus.count   = count_q;
    assign bus.cnt_dir = dir_q;

    // Arbitration, next-state decode and per-state control outputs.
    always_comb begin
        state_n      = state;
        grant        = 1'b0;
        win          = 1'b0;
        sel_op       = bus.op0;
        sel_arg      = bus.arg0;
        at_term      = 1'b0;
        step_sat     = 1'b0;
        bus.gnt      = 2'b00;
        bus.busy     = (state != IDLE);
        bus.done     = 1'b0;
        bus.done_id  = 1'b0;
        bus.sat_err  = 1'b0;
        bus.cnt_en   = 1'b0;
        bus.cnt_load = 1'b0;
        bus.load_val = '0;
        case (state)
            IDLE: begin
                if (!rst && bus.req != 2'b00) begin
                    grant   = 1'b1;
                    // Contention goes to rr_ptr; a lone request always wins.
                    win     = (bus.req == 2'b11) ? rr_ptr : bus.req[1];
                    bus.gnt = win ? 2'b10 : 2'b01;
                    sel_op  = win ? bus.op1  : bus.op0;
                    sel_arg = win ? bus.arg1 : bus.arg0;
                    case (sel_op)
                        OP_LOAD: state_n = LOAD;
                        OP_UP, OP_DOWN: begin
                            if (sel_arg == '0)
                                state_n = DONE;
                            else if ((sel_op == OP_UP) != dir_q)
                                state_n = SETTLE;
                            else
                                state_n = RUN;
                        end
                        default: state_n = (sel_arg == '0) ? DONE : HOLD;
                    endcase
                end
            end
            SETTLE: state_n = RUN;
            RUN: begin
                at_term = dir_q ? (count_q == {WIDTH{1'b1}}) : (count_q == '0);
                if (!WRAP && at_term) begin
                    // Step would cross a terminal value: suppress it and finish early.
                    step_sat = 1'b1;
                    state_n  = DONE;
                end else begin
                    bus.cnt_en = 1'b1;
                    if (rem == STEP_W'(1))
                        state_n = DONE;
                end
            end
            LOAD: begin
                bus.cnt_load = 1'b1;
                bus.load_val = load_q;
                state_n      = DONE;
            end
            HOLD: begin
                if (rem == STEP_W'(1))
                    state_n = DONE;
            end
            DONE: begin
                bus.done    = 1'b1;
                bus.done_id = owner;
                bus.sat_err = sat_q;
                state_n     = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    // State, command capture, count/direction update and remaining-step counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            count_q <= '0;
            dir_q   <= 1'b1;
            rr_ptr  <= 1'b0;
            owner   <= 1'b0;
            sat_q   <= 1'b0;
            rem     <= '0;
            load_q  <= '0;
        end else begin
            state <= state_n;
            if (grant) begin
                owner  <= win;
                rem    <= sel_arg;
                load_q <= sel_arg[WIDTH-1:0];
                sat_q  <= 1'b0;
                if (bus.req == 2'b11)
                    rr_ptr <= ~win;
                // New direction becomes visible during the settle cycle, with cnt_en low.
                if (state_n == SETTLE)
                    dir_q <= ~dir_q;
            end
            if (bus.cnt_load)
                count_q <= load_q;
            if (bus.cnt_en) begin
                count_q <= dir_q ? count_q + 1'b1 : count_q - 1'b1;
                rem     <= rem - 1'b1;
            end
            if (state == HOLD)
                rem <= rem - 1'b1;
            if (step_sat)
                sat_q <= 1'b1;
        end
    end
endmodule
